// File: rtl/enemy_draw.sv
// enemy_draw: sprite engine for the enemy box. Each accepted go request erases
// the box, steps it along a bounce-and-drop path, then redraws it, emitting
// one pixel per cycle on x/y/color qualified by plot.
//
// Handshake: go/kill are sampled only on a rising edge where the engine is
// idle and the enemy is alive; any request while busy=1 is dropped, not queued.
// done pulses for one cycle at the end of each accepted request.
module enemy_draw #(
    parameter int         SIZE    = 4,
    parameter logic [7:0] START_X = 8'd0,
    parameter logic [7:0] START_Y = 8'd10,
    parameter logic [7:0] X_MIN   = 8'd0,
    parameter logic [7:0] X_MAX   = 8'd156,
    parameter logic [7:0] Y_MAX   = 8'd112,
    parameter logic [7:0] STEP    = 8'd1,
    parameter logic [7:0] DROP    = 8'd4,
    parameter logic [2:0] COLOR   = 3'b100
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       go,
    input  logic       kill,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       alive
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_UPDATE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(SIZE - 1);

    state_t     state;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic       dir;
    logic       kill_q;
    logic [3:0] dx;
    logic [3:0] dy;

    logic [8:0] right_sum;
    logic [8:0] left_lim;
    logic [8:0] drop_sum;
    logic [7:0] drop_y;
    logic [7:0] new_x;
    logic [7:0] new_y;
    logic       new_dir;
    logic [3:0] nxt_dx;
    logic [3:0] nxt_dy;
    logic       last_px;

    // Next position/direction along the bounce-and-drop path (9-bit so no wrap)
    always_comb begin
        right_sum = {1'b0, pos_x} + {1'b0, STEP};
        left_lim  = {1'b0, X_MIN} + {1'b0, STEP};
        drop_sum  = {1'b0, pos_y} + {1'b0, DROP};
        drop_y    = (drop_sum > {1'b0, Y_MAX}) ? Y_MAX : drop_sum[7:0];
        new_x     = pos_x;
        new_y     = pos_y;
        new_dir   = dir;
        if (!dir) begin
            if (right_sum > {1'b0, X_MAX}) begin
                new_x   = X_MAX;
                new_dir = 1'b1;
                new_y   = drop_y;
            end else begin
                new_x = right_sum[7:0];
            end
        end else begin
            if ({1'b0, pos_x} < left_lim) begin
                new_x   = X_MIN;
                new_dir = 1'b0;
                new_y   = drop_y;
            end else begin
                new_x = pos_x - STEP;
            end
        end
    end

    // Row-major scan counter advance; dx is the fast index
    always_comb begin
        last_px = (dx == LAST) && (dy == LAST);
        nxt_dx  = (dx == LAST) ? 4'd0 : dx + 4'd1;
        nxt_dy  = (dx == LAST) ? dy + 4'd1 : dy;
    end

    // Control FSM; pixel outputs are registered for the cycle being entered
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            pos_x  <= START_X;
            pos_y  <= START_Y;
            dir    <= 1'b0;
            alive  <= 1'b1;
            kill_q <= 1'b0;
            dx     <= 4'd0;
            dy     <= 4'd0;
            x      <= 8'd0;
            y      <= 8'd0;
            color  <= 3'b000;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (go && alive) begin
                        state  <= S_ERASE;
                        kill_q <= kill;
                        dx     <= 4'd0;
                        dy     <= 4'd0;
                        x      <= pos_x;
                        y      <= pos_y;
                        color  <= 3'b000;
                        plot   <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (last_px) begin
                        dx   <= 4'd0;
                        dy   <= 4'd0;
                        plot <= 1'b0;
                        if (kill_q) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            alive <= 1'b0;
                        end else begin
                            state <= S_UPDATE;
                        end
                    end else begin
                        dx <= nxt_dx;
                        dy <= nxt_dy;
                        x  <= pos_x + 8'(nxt_dx);
                        y  <= pos_y + 8'(nxt_dy);
                    end
                end
                S_UPDATE: begin
                    state <= S_DRAW;
                    pos_x <= new_x;
                    pos_y <= new_y;
                    dir   <= new_dir;
                    dx    <= 4'd0;
                    dy    <= 4'd0;
                    x     <= new_x;
                    y     <= new_y;
                    color <= COLOR;
                    plot  <= 1'b1;
                end
                S_DRAW: begin
                    if (last_px) begin
                        state <= S_DONE;
                        dx    <= 4'd0;
                        dy    <= 4'd0;
                        plot  <= 1'b0;
                        color <= 3'b000;
                        done  <= 1'b1;
                    end else begin
                        dx <= nxt_dx;
                        dy <= nxt_dy;
                        x  <= pos_x + 8'(nxt_dx);
                        y  <= pos_y + 8'(nxt_dy);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    kill_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
